// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: one full-subtractor cell plus a borrow flop resolves
// one difference bit per clock, LSB first, then presents diff/borrow/zero with a done pulse.
module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [WIDTH-1:0] i_in1,
    input  logic [WIDTH-1:0] i_in2,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_diff,
    output logic             o_borrow,
    output logic             o_zero
);

    localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LastCnt = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           r_state;
    logic [WIDTH-1:0] r_a_sr;
    logic [WIDTH-1:0] r_b_sr;
    logic [WIDTH-1:0] r_d_sr;
    logic             r_br;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    logic             r_done;
    logic [WIDTH-1:0] r_diff;
    logic             r_borrow;
    logic             r_zero;

    logic             w_a;
    logic             w_b;
    logic             w_hs1_d;
    logic             w_hs1_b;
    logic             w_hs2_d;
    logic             w_hs2_b;
    logic             w_br_next;
    logic [WIDTH-1:0] w_d_next;

    // Full subtractor built from two half subtractors: a - b, then - borrow_in.
    always_comb begin
        w_a       = r_a_sr[0];
        w_b       = r_b_sr[0];
        w_hs1_d   = w_a ^ w_b;
        w_hs1_b   = ~w_a & w_b;
        w_hs2_d   = w_hs1_d ^ r_br;
        w_hs2_b   = ~w_hs1_d & r_br;
        w_br_next = w_hs1_b | w_hs2_b;
        w_d_next  = {w_hs2_d, r_d_sr[WIDTH-1:1]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= StIdle;
            r_a_sr   <= '0;
            r_b_sr   <= '0;
            r_d_sr   <= '0;
            r_br     <= 1'b0;
            r_cnt    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_diff   <= '0;
            r_borrow <= 1'b0;
            r_zero   <= 1'b0;
        end else begin
            unique case (r_state)
                StIdle, StDone: begin
                    r_done <= 1'b0;
                    if (i_start) begin
                        r_a_sr  <= i_in1;
                        r_b_sr  <= i_in2;
                        r_d_sr  <= '0;
                        r_br    <= 1'b0;
                        r_cnt   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= StRun;
                    end else begin
                        r_state <= StIdle;
                    end
                end
                StRun: begin
                    r_a_sr <= {1'b0, r_a_sr[WIDTH-1:1]};
                    r_b_sr <= {1'b0, r_b_sr[WIDTH-1:1]};
                    r_d_sr <= w_d_next;
                    r_br   <= w_br_next;
                    // Last bit: publish results on the same edge it is resolved.
                    if (r_cnt == LastCnt) begin
                        r_diff   <= w_d_next;
                        r_borrow <= w_br_next;
                        r_zero   <= (w_d_next == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                        r_state  <= StDone;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy   = r_busy;
    assign o_done   = r_done;
    assign o_diff   = r_diff;
    assign o_borrow = r_borrow;
    assign o_zero   = r_zero;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor (WIDTH=8): latency, results, ignored start,
// back-to-back operation and asynchronous reset mid-run.
module tb_serial_subtractor;

    localparam int unsigned W = 8;

    logic         clk;
    logic         rst_n;
    logic         i_start;
    logic [W-1:0] i_in1;
    logic [W-1:0] i_in2;
    logic         o_busy;
    logic         o_done;
    logic [W-1:0] o_diff;
    logic         o_borrow;
    logic         o_zero;

    int total;
    int bad;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_start  (i_start),
        .i_in1    (i_in1),
        .i_in2    (i_in2),
        .o_busy   (o_busy),
        .o_done   (o_done),
        .o_diff   (o_diff),
        .o_borrow (o_borrow),
        .o_zero   (o_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Called on a falling edge while the DUT is idle or in its done cycle.
    task automatic launch(input logic [W-1:0] a, input logic [W-1:0] b);
        i_in1   = a;
        i_in2   = b;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    // Entered on the falling edge right after the accepting edge; returns in the done cycle.
    task automatic finish_op(input string tag, input logic [W-1:0] ed, input logic eb,
                             input logic ez, input logic [W-1:0] hold_d, input int inj);
        int  nbusy;
        int  both;
        int  moved;
        bit  seen;
        nbusy = 0;
        both  = 0;
        moved = 0;
        seen  = 0;
        for (int k = 0; k < 40 && !seen; k++) begin
            if (o_busy) nbusy++;
            if (o_busy && o_done) both++;
            if (o_done) begin
                seen = 1;
            end else begin
                if (o_diff !== hold_d) moved++;
                i_start = (k == inj);
                if (k == inj) begin
                    i_in1 = 8'hFF;
                    i_in2 = 8'h00;
                end
                @(negedge clk);
                i_start = 1'b0;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
        check({tag, "_busy_cycles"}, 32'(nbusy), 32'd8);
        check({tag, "_busy_done_overlap"}, 32'(both), 32'd0);
        check({tag, "_held_during_run"}, 32'(moved), 32'd0);
        check({tag, "_diff"}, 32'(o_diff), 32'(ed));
        check({tag, "_borrow"}, 32'(o_borrow), 32'(eb));
        check({tag, "_zero"}, 32'(o_zero), 32'(ez));
    endtask

    task automatic count_done(input int cycles, output int n);
        n = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (o_done) n++;
        end
    endtask

    initial begin
        int n;
        total   = 0;
        bad     = 0;
        rst_n   = 1'b0;
        i_start = 1'b0;
        i_in1   = '0;
        i_in2   = '0;

        #12;
        check("rst_busy", 32'(o_busy), 32'd0);
        check("rst_done", 32'(o_done), 32'd0);
        check("rst_diff", 32'(o_diff), 32'd0);
        check("rst_borrow", 32'(o_borrow), 32'd0);
        check("rst_zero", 32'(o_zero), 32'd0);

        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (o_busy || o_done) n++;
        end
        check("idle_quiet", 32'(n), 32'd0);

        launch(8'h5A, 8'h23);
        finish_op("basic", 8'h37, 1'b0, 1'b0, 8'h00, -1);
        @(negedge clk);
        check("basic_done_falls", 32'(o_done), 32'd0);
        check("basic_result_kept", 32'(o_diff), 32'h37);

        launch(8'h03, 8'h05);
        finish_op("under1", 8'hFE, 1'b1, 1'b0, 8'h37, -1);
        @(negedge clk);

        launch(8'h00, 8'hFF);
        finish_op("under2", 8'h01, 1'b1, 1'b0, 8'hFE, -1);
        @(negedge clk);

        launch(8'hA5, 8'hA5);
        finish_op("equal", 8'h00, 1'b0, 1'b1, 8'h01, 2);
        count_done(14, n);
        check("ignored_no_extra_done", 32'(n), 32'd0);
        check("ignored_diff_kept", 32'(o_diff), 32'h00);
        check("ignored_zero_kept", 32'(o_zero), 32'd1);

        launch(8'h20, 8'h08);
        finish_op("b2b_first", 8'h18, 1'b0, 1'b0, 8'h00, -1);
        launch(8'h10, 8'h01);
        finish_op("b2b_second", 8'h0F, 1'b0, 1'b0, 8'h18, -1);
        @(negedge clk);

        launch(8'hAA, 8'h11);
        for (int k = 0; k < 3; k++) @(negedge clk);
        check("mid_busy_before_rst", 32'(o_busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_busy", 32'(o_busy), 32'd0);
        check("mid_rst_done", 32'(o_done), 32'd0);
        check("mid_rst_diff", 32'(o_diff), 32'd0);
        check("mid_rst_borrow", 32'(o_borrow), 32'd0);
        check("mid_rst_zero", 32'(o_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(14, n);
        check("post_rst_no_done", 32'(n), 32'd0);

        launch(8'h80, 8'h7F);
        finish_op("after_rst", 8'h01, 1'b0, 1'b0, 8'h00, -1);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
